// File: rtl/ex_stage_if.sv
// ex_stage_if: ID/EX operand and control bundle into the execute stage, EX/MEM results out.
interface ex_stage_if;
    logic        Stall, Flush, Shift_In, S_In;
    logic        rf_In, Load_In, Enable_In, rw_In;
    logic [3:0]  ALU_In, Rd_In;
    logic [1:0]  Size_In;
    logic [31:0] PortA_In, PortB_In, PortC_In;
    logic [11:0] Shifter_Amount_In;
    logic [31:0] ALU_Result_Out, Store_Data_Out, Fwd_Result;
    logic [3:0]  Rd_Out, Flags_Out;
    logic [1:0]  Size_Out;
    logic        rf_Out, Load_Out, Enable_Out, rw_Out;

    modport master (
        output Stall, Flush, Shift_In, S_In, rf_In, Load_In, Enable_In, rw_In,
               ALU_In, Rd_In, Size_In, PortA_In, PortB_In, PortC_In, Shifter_Amount_In,
        input  ALU_Result_Out, Store_Data_Out, Fwd_Result, Rd_Out, Flags_Out, Size_Out,
               rf_Out, Load_Out, Enable_Out, rw_Out
    );
    modport slave (
        input  Stall, Flush, Shift_In, S_In, rf_In, Load_In, Enable_In, rw_In,
               ALU_In, Rd_In, Size_In, PortA_In, PortB_In, PortC_In, Shifter_Amount_In,
        output ALU_Result_Out, Store_Data_Out, Fwd_Result, Rd_Out, Flags_Out, Size_Out,
               rf_Out, Load_Out, Enable_Out, rw_Out
    );
endinterface

// File: rtl/ex_stage.sv
// ex_stage: operand-2 shifter, ARM data-processing ALU, NZCV register and EX/MEM pipeline register.
module ex_stage #(
    parameter int DW = 32
) (
    input logic      CLK,
    input logic      CLR_N,
    ex_stage_if.slave bus
);
    function automatic logic [DW-1:0] ror(input logic [DW-1:0] x, input logic [4:0] n);
        logic [2*DW-1:0] t;
        t = {x, x} >> n;
        return t[DW-1:0];
    endfunction

    logic [3:0]    flags_q, flags_d, rd_q, ctl_q, op;
    logic [1:0]    size_q, typ;
    logic [DW-1:0] res_q, st_q, a, b, imm_v, ror_v, op2, x, y0, y, res;
    logic [DW:0]   lsl_t, lsr_t, asr_t, sum;
    logic [4:0]    amt, rot;
    logic [5:0]    n;
    logic          c, sh_c, ci, arith, rev, inv;

    // LSR/ASR with a zero amount field mean a shift by 32; the extra low bit catches the carry-out
    always_comb begin
        a     = bus.PortA_In;
        b     = bus.PortB_In;
        c     = flags_q[1];
        rot   = {bus.Shifter_Amount_In[11:8], 1'b0};
        amt   = bus.Shifter_Amount_In[11:7];
        typ   = bus.Shifter_Amount_In[6:5];
        n     = (amt == 5'd0) ? 6'd32 : {1'b0, amt};
        imm_v = ror({{(DW-8){1'b0}}, bus.Shifter_Amount_In[7:0]}, rot);
        ror_v = (amt == 5'd0) ? {c, b[DW-1:1]} : ror(b, amt);
        lsl_t = {1'b0, b} << amt;
        lsr_t = {b, 1'b0} >> n;
        asr_t = $signed({b, 1'b0}) >>> n;
        op2   = bus.Shift_In ? imm_v :
                typ == 2'd0  ? lsl_t[DW-1:0] :
                typ == 2'd1  ? lsr_t[DW:1] :
                typ == 2'd2  ? asr_t[DW:1] : ror_v;
        sh_c  = bus.Shift_In ? ((rot == 5'd0) ? c : imm_v[DW-1]) :
                typ == 2'd0  ? ((amt == 5'd0) ? c : lsl_t[DW]) :
                typ == 2'd1  ? lsr_t[0] :
                typ == 2'd2  ? asr_t[0] :
                ((amt == 5'd0) ? b[0] : ror_v[DW-1]);
    end

    // One adder serves every arithmetic op: reverse ops swap operands, subtracts invert the subtrahend
    always_comb begin
        op    = bus.ALU_In;
        rev   = op == 4'h3 || op == 4'h7;
        inv   = op == 4'h2 || op == 4'h3 || op == 4'h6 || op == 4'h7 || op == 4'hA;
        ci    = (op == 4'h2 || op == 4'h3 || op == 4'hA) ? 1'b1 :
                (op == 4'h5 || op == 4'h6 || op == 4'h7) ? c : 1'b0;
        arith = (op >= 4'h2 && op <= 4'h7) || op == 4'hA || op == 4'hB;
        x     = rev ? op2 : a;
        y0    = rev ? a : op2;
        y     = inv ? ~y0 : y0;
        sum   = {1'b0, x} + {1'b0, y} + {{DW{1'b0}}, ci};
        res   = sum[DW-1:0];
        case (op)
            4'h0, 4'h8: res = a & op2;
            4'h1, 4'h9: res = a ^ op2;
            4'hC:       res = a | op2;
            4'hD:       res = op2;
            4'hE:       res = a & ~op2;
            4'hF:       res = ~op2;
            default:    res = sum[DW-1:0];
        endcase
        flags_d = {res[DW-1], res == '0, arith ? sum[DW] : sh_c,
                   arith ? (x[DW-1] == y[DW-1] && sum[DW-1] != x[DW-1]) : flags_q[0]};
    end

    always_ff @(posedge CLK) begin
        if (!CLR_N) begin
            res_q   <= '0;
            st_q    <= '0;
            rd_q    <= '0;
            size_q  <= '0;
            ctl_q   <= '0;
            flags_q <= '0;
        end else if (bus.Flush) begin
            res_q  <= '0;
            st_q   <= '0;
            rd_q   <= '0;
            size_q <= '0;
            ctl_q  <= '0;
        end else if (!bus.Stall) begin
            res_q  <= res;
            st_q   <= bus.PortC_In;
            rd_q   <= bus.Rd_In;
            size_q <= bus.Size_In;
            ctl_q  <= {bus.rf_In, bus.Load_In, bus.Enable_In, bus.rw_In};
            if (bus.S_In) flags_q <= flags_d;
        end
    end

    assign bus.ALU_Result_Out = res_q;
    assign bus.Store_Data_Out = st_q;
    assign bus.Rd_Out         = rd_q;
    assign bus.Size_Out       = size_q;
    assign {bus.rf_Out, bus.Load_Out, bus.Enable_Out, bus.rw_Out} = ctl_q;
    assign bus.Flags_Out      = flags_q;
    assign bus.Fwd_Result     = res;
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed execute-stage sequence with an expected-state queue checked after each edge.
module tb_ex_stage;
    localparam logic [1:0] RUN = 2'd0, STALL = 2'd1, FLUSH = 2'd2, RESET = 2'd3;

    logic clk = 1'b0;
    logic clr_n = 1'b0;
    always #5 clk = ~clk;

    ex_stage_if bus ();
    ex_stage #(.DW(32)) dut (.CLK(clk), .CLR_N(clr_n), .bus(bus));

    typedef struct {
        logic [31:0] res, st;
        logic [3:0]  rd, fl, ctl;
        logic [1:0]  sz;
    } exp_t;

    exp_t sb[$];
    exp_t last = '{default: '0};
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // mode: RUN captures, STALL holds, FLUSH (with Stall also high) zeroes, RESET (mid-stall) zeroes all
    task automatic step(input string tag, input logic [1:0] mode, input logic [3:0] op, input logic si,
                        input logic [11:0] sh, input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [31:0] er, input logic [3:0] ef);
        exp_t e;
        bus.ALU_In = op;
        bus.Shift_In = si;
        bus.Shifter_Amount_In = sh;
        bus.PortA_In = a;
        bus.PortB_In = b;
        bus.S_In = s;
        bus.PortC_In = $urandom;
        bus.Rd_In = 4'($urandom);
        bus.Size_In = 2'($urandom);
        {bus.rf_In, bus.Load_In, bus.Enable_In, bus.rw_In} = 4'($urandom);
        bus.Stall = mode != RUN;
        bus.Flush = mode == FLUSH;
        clr_n = mode != RESET;
        e.res = mode == RUN ? er : mode == STALL ? last.res : '0;
        e.st  = mode == RUN ? bus.PortC_In : mode == STALL ? last.st : '0;
        e.rd  = mode == RUN ? bus.Rd_In : mode == STALL ? last.rd : '0;
        e.sz  = mode == RUN ? bus.Size_In : mode == STALL ? last.sz : '0;
        e.ctl = mode == RUN ? {bus.rf_In, bus.Load_In, bus.Enable_In, bus.rw_In} : mode == STALL ? last.ctl : '0;
        e.fl  = ef;
        sb.push_back(e);
        #1;
        if (mode == RUN) chk({tag, "/fwd"}, bus.Fwd_Result, er);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, "/result"}, bus.ALU_Result_Out, e.res);
        chk({tag, "/store"}, bus.Store_Data_Out, e.st);
        chk({tag, "/rd"}, 32'(bus.Rd_Out), 32'(e.rd));
        chk({tag, "/size"}, 32'(bus.Size_Out), 32'(e.sz));
        chk({tag, "/ctl"}, 32'({bus.rf_Out, bus.Load_Out, bus.Enable_Out, bus.rw_Out}), 32'(e.ctl));
        chk({tag, "/nzcv"}, 32'(bus.Flags_Out), 32'(e.fl));
        last = e;
    endtask

    initial begin
        step("rst0",    RESET, 4'h4, 1'b1, 12'h001, 32'h1234, 32'h5678, 1'b1, 32'h0, 4'h0);
        step("rst1",    RESET, 4'h4, 1'b1, 12'h001, 32'h1234, 32'h5678, 1'b1, 32'h0, 4'h0);
        step("adds_v",  RUN, 4'h4, 1'b1, 12'h001, 32'h7FFFFFFF, 32'h0, 1'b1, 32'h80000000, 4'h9);
        step("subs_z",  RUN, 4'h2, 1'b0, 12'h000, 32'h5, 32'h5, 1'b1, 32'h0, 4'h6);
        step("adc",     RUN, 4'h5, 1'b1, 12'h001, 32'h1, 32'h0, 1'b0, 32'h3, 4'h6);
        step("asr32",   RUN, 4'hD, 1'b0, 12'h040, 32'h0, 32'h80000001, 1'b1, 32'hFFFFFFFF, 4'hA);
        step("rrx",     RUN, 4'hD, 1'b0, 12'h060, 32'h0, 32'h80000001, 1'b1, 32'hC0000000, 4'hA);
        step("lsr1",    RUN, 4'hD, 1'b0, 12'h0A0, 32'h0, 32'h2, 1'b1, 32'h1, 4'h0);
        step("imm_rot", RUN, 4'hD, 1'b1, 12'h4FF, 32'h0, 32'h0, 1'b1, 32'hFF000000, 4'hA);
        step("imm_r0",  RUN, 4'hD, 1'b1, 12'h000, 32'h0, 32'h0, 1'b1, 32'h0, 4'h6);
        step("lsl4",    RUN, 4'hD, 1'b0, 12'h200, 32'h0, 32'hF0000001, 1'b1, 32'h10, 4'h2);
        step("cmp",     RUN, 4'hA, 1'b1, 12'h005, 32'h3, 32'h0, 1'b1, 32'hFFFFFFFE, 4'h8);
        step("rsb",     RUN, 4'h3, 1'b1, 12'h001, 32'h1, 32'h0, 1'b1, 32'h0, 4'h6);
        step("sbc",     RUN, 4'h6, 1'b1, 12'h003, 32'hA, 32'h0, 1'b0, 32'h7, 4'h6);
        step("eor",     RUN, 4'h1, 1'b0, 12'h000, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 32'hF0F0F0F0, 4'h6);
        step("bics",    RUN, 4'hE, 1'b1, 12'h0FF, 32'hFFFFFFFF, 32'h0, 1'b1, 32'hFFFFFF00, 4'hA);
        step("rscs",    RUN, 4'h7, 1'b1, 12'h000, 32'h0, 32'h0, 1'b1, 32'h0, 4'h6);
        step("teq",     RUN, 4'h9, 1'b1, 12'h005, 32'h5, 32'h0, 1'b1, 32'h0, 4'h6);
        step("pre_stl", RUN, 4'h4, 1'b1, 12'h002, 32'h1, 32'h0, 1'b1, 32'h3, 4'h0);
        for (int i = 0; i < 3; i++)
            step("stall", STALL, 4'hD, 1'b1, 12'h000, 32'h0, 32'h0, 1'b1, 32'h0, 4'h0);
        step("release", RUN, 4'h2, 1'b1, 12'h001, 32'h0, 32'h0, 1'b1, 32'hFFFFFFFF, 4'h8);
        step("flush",   FLUSH, 4'h4, 1'b1, 12'h001, 32'h0, 32'h0, 1'b1, 32'h0, 4'h8);
        step("orr",     RUN, 4'hC, 1'b1, 12'h00F, 32'hF0, 32'h0, 1'b0, 32'hFF, 4'h8);
        step("rst_stl", RESET, 4'h4, 1'b1, 12'h001, 32'h1, 32'h0, 1'b1, 32'h0, 4'h0);
        step("mvns",    RUN, 4'hF, 1'b1, 12'h000, 32'h0, 32'h0, 1'b1, 32'hFFFFFFFF, 4'h8);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
